// File: rtl/prog_loader.sv
// prog_loader: loads a program into instruction memory from a byte stream.
//
// Stream: LEN_LO, LEN_HI (N words), N x 4 bytes little-endian, 1 checksum byte.
// The checksum is the mod-256 sum of the 4N word bytes. The core is held in
// reset (cpu_reset=1) except after a load that ended with a good checksum.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   start                 pulse to begin a load (ignored while busy)
//   rx_valid/rx_data      byte source; rx_ready accepts a byte
//   imem_we/addr/wdata    one-cycle word write into instruction memory
//   cpu_reset             active-high core hold
//   busy, done, err       load status
module prog_loader #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(DEPTH_WORDS);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] n_words;
  logic [15:0] k;
  logic [7:0]  sum;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_q;

  logic        xfer;
  logic [16:0] len_full;
  logic [16:0] k_next;

  assign xfer     = rx_valid & rx_ready;
  assign len_full = {1'b0, rx_data, len_lo};
  assign k_next   = {1'b0, k} + 17'd1;

  // Status outputs are pure decodes of the state register, so they change
  // only on clock edges and never glitch.
  assign rx_ready  = (state == LEN0) || (state == LEN1) ||
                     (state == DATA) || (state == CSUM);
  assign busy      = (state == LEN0) || (state == LEN1) || (state == DATA) ||
                     (state == WRITE) || (state == CSUM);
  assign imem_we   = (state == WRITE);
  assign cpu_reset = (state != DONE);
  assign done      = (state == DONE);
  assign err       = (state == ERR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      len_lo     <= '0;
      n_words    <= '0;
      k          <= '0;
      sum        <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LEN0;
            k        <= '0;
            byte_cnt <= '0;
            sum      <= '0;
          end
        end
        LEN0: begin
          if (xfer) begin
            len_lo <= rx_data;
            state  <= LEN1;
          end
        end
        LEN1: begin
          if (xfer) begin
            n_words <= {rx_data, len_lo};
            if (len_full == 17'd0)    state <= CSUM;
            else if (len_full > DEPTH) state <= ERR;
            else                       state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            // Shift in from the top so the first byte ends up in [7:0].
            asm_q    <= {rx_data, asm_q[31:8]};
            sum      <= sum + rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Address/data are captured here so they hold outside WRITE.
              imem_addr  <= {14'd0, k, 2'b00};
              imem_wdata <= {rx_data, asm_q[31:8]};
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          k     <= k + 16'd1;
          state <= (k_next < {1'b0, n_words}) ? DATA : CSUM;
        end
        CSUM: begin
          if (xfer) state <= (rx_data == sum) ? DONE : ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
